tone_sequencer: RTL
===================

# tone_sequencer

Parametrised square-wave sequence player driving the board audio PWM pin. Holds NUM_SEQS programmable sequences of SEQ_LEN notes, each note stored as a half-period in clock cycles (0 = rest). On a start pulse it plays the selected sequence once or in a loop. Each note lasts a fixed NOTE_TICKS and ends in a silent articulation gap so that repeated notes stay distinct. It sits between game-control logic (start/stop/select) and the audio jack output.

## Interface
- CLOCK_FREQ, 50_000_000: clock rate in Hz; documentation and host-side half-period computation only.
- NUM_SEQS, 4: number of stored sequences, ≥1.
- SEQ_LEN, 8: notes per sequence, ≥2, power of two.
- HALF_W, 20: half-period field width.
- NOTE_TICKS, 25_000_000: cycles per note including gap, ≥2.
- GAP_TICKS, 2_500_000: silent cycles at end of each note, 0 ≤ GAP_TICKS < NOTE_TICKS.
- SEL_W = max(1,$clog2(NUM_SEQS)) and IDX_W = $clog2(SEQ_LEN): derived local widths.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  table write strobe.
- wr_seq  in  SEL_W  sequence written.
- wr_idx  in  IDX_W  note index written.
- wr_half  in  HALF_W  half-period in cycles; 0 = rest.
- start  in  1  play request, sampled only in IDLE.
- seq_sel  in  SEL_W  sequence to play, latched with start.
- loop  in  1  loop mode, latched with start.
- stop  in  1  abort playback.
- audio_out  out  1  square wave to the PWM pin.
- audio_en  out  1  amplifier enable; equals busy.
- busy  out  1  high in PLAY or GAP.
- done  out  1  one-cycle pulse at end of a non-looped sequence.
- note_idx  out  IDX_W  index of the current note.

## Operation
- Table: NUM_SEQS×SEQ_LEN×HALF_W register array.
  - Unaffected by reset; contents are undefined until written.
  - A write takes effect on the edge where wr_en is high.
  - Writes are legal at any time, including during playback.
- Per-note registers: half (latched copy of the table entry), note counter nc, half-period counter hc, tone.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - start=1 and stop=0: latch seq_sel and loop; set note_idx=0; load half = table[seq][0]; nc=0, hc=0, tone=0; go to PLAY.
  - stop=1 has priority over start; the FSM stays in IDLE.
- PLAY:
  - nc increments every cycle.
  - If half≠0: hc increments; when hc==half-1, set hc=0 and toggle tone.
  - If half=0: tone is held at 0.
  - When nc==NOTE_TICKS-GAP_TICKS-1: if GAP_TICKS>0, go to GAP (tone=0, hc=0); otherwise do the note advance.
- GAP: tone=0; nc keeps counting; at nc==NOTE_TICKS-1, do the note advance.
- Note advance:
  - note_idx<SEQ_LEN-1: increment note_idx; load the next half; nc=0, hc=0, tone=0; go to PLAY.
  - Last note with loop=1: wrap note_idx to 0 and continue.
  - Last note with loop=0: go to IDLE and pulse done for one cycle.
- stop in PLAY or GAP: next edge goes to IDLE with tone=0 and no done pulse.
- start while busy is ignored; no queueing.
- A write to the playing sequence changes a note only when that index is next loaded. The currently playing half is unaffected.
- audio_out is the tone register. It is 0 in IDLE and GAP, and 0 for rests.
- Reset (any time, including mid-note): state=IDLE; note_idx, nc, hc, tone, done=0; loop and seq latches cleared. All outputs go to 0 immediately (asynchronous).

## Timing
- start accepted at edge k: busy and audio_en are high after edge k.
- First audio_out rise is after edge k+half. Output period is 2·half cycles at 50% duty.
- Each note occupies exactly NOTE_TICKS cycles: NOTE_TICKS-GAP_TICKS sounding cycles, then GAP_TICKS silent cycles.
- Non-looped sequence started at edge k:
  - busy falls after edge k+SEQ_LEN·NOTE_TICKS.
  - done is high for that one cycle only.
- A new start is accepted at the earliest on the edge after busy falls.
- stop sampled at edge m: busy=0 and audio_out=0 after edge m.
- done and stop never assert together.
- half=1 toggles tone every cycle, giving a clk/2 square wave.

## Test plan
Bench parameters: NUM_SEQS=2, SEQ_LEN=4, HALF_W=8, NOTE_TICKS=20, GAP_TICKS=4.

- Write seq0={3,0,5,3}, then start with seq_sel=0, loop=0 at edge k.
  - Note 0: audio_out toggles every 3 cycles for cycles k..k+15, then low for 4 cycles.
  - Note 1: silent.
  - Note 2: toggles every 5 cycles.
  - busy falls and done pulses once after edge k+80.
- Same table with loop=1: note_idx wraps 3→0 with no done pulse; stop at edge k+50 gives busy=0 and audio_out=0 after that edge, with no done.
- Start during playback is ignored (note_idx and timing unchanged). start and stop together in IDLE leave busy=0.
- Assert reset_n low mid-note with tone=1: audio_out, busy, done and note_idx are 0 before the next clk edge. After release, a new start plays normally from note 0.
- During note 0 of seq1:
  - Rewrite seq1[0]=7: the current note's period is unchanged.
  - Rewrite seq1[2]=2: note 2 toggles every 2 cycles.
- GAP_TICKS=0 variant with seq={4,4,4,4}: tone is reset to 0 at every 20-cycle boundary, and busy stays high for exactly 80 cycles.

Source files
------------

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays stored square-wave note sequences on the audio pin.
// Ports: clk, reset_n (async low); table write wr_en/wr_seq/wr_idx/wr_half;
//   control start/seq_sel/loop/stop; audio_out, audio_en, busy, done, note_idx.
module tone_sequencer #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int NUM_SEQS   = 4,
    parameter int SEQ_LEN    = 8,
    parameter int HALF_W     = 20,
    parameter int NOTE_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 2_500_000,
    localparam int SEL_W     = (NUM_SEQS > 1) ? $clog2(NUM_SEQS) : 1,
    localparam int IDX_W     = $clog2(SEQ_LEN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_seq,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [HALF_W-1:0] wr_half,
    input  logic              start,
    input  logic [SEL_W-1:0]  seq_sel,
    input  logic              loop,
    input  logic              stop,
    output logic              audio_out,
    output logic              audio_en,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  note_idx
);

    localparam int NC_W = $clog2(NOTE_TICKS);
    localparam logic [NC_W-1:0] PLAY_END = NC_W'(NOTE_TICKS - GAP_TICKS - 1);
    localparam logic [NC_W-1:0] NOTE_END = NC_W'(NOTE_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    if (CLOCK_FREQ < 1 || NUM_SEQS < 1 || SEQ_LEN < 2 || NOTE_TICKS < 2 ||
        GAP_TICKS < 0 || GAP_TICKS >= NOTE_TICKS) begin : g_bad_param
        $error("tone_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [HALF_W-1:0] tbl [NUM_SEQS][SEQ_LEN];

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx_n;
    logic [NC_W-1:0]   nc, nc_n;
    logic [HALF_W-1:0] hc, hc_n;
    logic [HALF_W-1:0] half, half_n;
    logic              tone, tone_n;
    logic              done_q, done_n;
    logic [SEL_W-1:0]  seq_q, seq_n;
    logic              loop_q, loop_n;
    logic              advance;

    // The note table is deliberately outside reset; the host fills it.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_seq) < NUM_SEQS)) begin
            tbl[wr_seq][wr_idx] <= wr_half;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            note_idx <= '0;
            nc       <= '0;
            hc       <= '0;
            half     <= '0;
            tone     <= 1'b0;
            done_q   <= 1'b0;
            seq_q    <= '0;
            loop_q   <= 1'b0;
        end else begin
            state    <= state_n;
            note_idx <= idx_n;
            nc       <= nc_n;
            hc       <= hc_n;
            half     <= half_n;
            tone     <= tone_n;
            done_q   <= done_n;
            seq_q    <= seq_n;
            loop_q   <= loop_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = note_idx;
        nc_n    = nc;
        hc_n    = hc;
        half_n  = half;
        tone_n  = tone;
        done_n  = 1'b0;
        seq_n   = seq_q;
        loop_n  = loop_q;
        advance = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    seq_n   = seq_sel;
                    loop_n  = loop;
                    idx_n   = '0;
                    half_n  = tbl[seq_sel][IDX_W'(0)];
                    nc_n    = '0;
                    hc_n    = '0;
                    tone_n  = 1'b0;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                nc_n = nc + 1'b1;
                if (half != '0) begin
                    if (hc == half - 1'b1) begin
                        hc_n   = '0;
                        tone_n = ~tone;
                    end else begin
                        hc_n = hc + 1'b1;
                    end
                end else begin
                    tone_n = 1'b0;
                end
                if (nc == PLAY_END) begin
                    if (GAP_TICKS > 0) begin
                        state_n = GAP;
                        tone_n  = 1'b0;
                        hc_n    = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            GAP: begin
                tone_n = 1'b0;
                nc_n   = nc + 1'b1;
                if (nc == NOTE_END) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The next note is read from the table only here, so table writes
        // never disturb the note already sounding.
        if (advance) begin
            nc_n   = '0;
            hc_n   = '0;
            tone_n = 1'b0;
            if (note_idx == LAST_IDX && !loop_q) begin
                state_n = IDLE;
                idx_n   = '0;
                done_n  = 1'b1;
            end else begin
                idx_n   = note_idx + 1'b1;
                half_n  = tbl[seq_q][idx_n];
                state_n = PLAY;
            end
        end

        if (stop && state != IDLE) begin
            state_n = IDLE;
            idx_n   = '0;
            tone_n  = 1'b0;
            hc_n    = '0;
            nc_n    = '0;
            done_n  = 1'b0;
        end
    end

    assign audio_out = tone;
    assign busy      = (state != IDLE);
    assign audio_en  = busy;
    assign done      = done_q;

endmodule
